// File: rtl/mem_pipe_stage.sv
// MEM pipeline stage: EX/MEM register, word-addressed data memory with
// synchronous read, MEM/WB register and write-back select. Misaligned
// accesses never touch memory; misaligned loads return zero and do not
// write the register file.
module mem_pipe_stage #(
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] id_ex_instr,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_in2_out,
    input  logic        id_ex_mem_read,
    input  logic        id_ex_mem_write,
    input  logic        id_ex_mem_to_reg,
    input  logic        id_ex_reg_write,
    input  logic [4:0]  id_ex_write_reg_addr,
    output logic [31:0] ex_mem_instr,
    output logic [31:0] ex_mem_alu_result,
    output logic        ex_mem_reg_write,
    output logic [4:0]  ex_mem_write_reg_addr,
    output logic        ex_mem_mem_read,
    output logic        mem_wb_reg_write,
    output logic [4:0]  mem_wb_write_reg_addr,
    output logic [31:0] mem_wb_write_back_result,
    output logic        mem_wb_misaligned
);

    localparam int AW = $clog2(DMEM_WORDS);

    // EX/MEM register
    logic [31:0] ex_mem_instr_r;
    logic [31:0] ex_mem_alu_result_r;
    logic [31:0] ex_mem_rt_data_r;
    logic        ex_mem_mem_read_r;
    logic        ex_mem_mem_write_r;
    logic        ex_mem_mem_to_reg_r;
    logic        ex_mem_reg_write_r;
    logic [4:0]  ex_mem_write_reg_addr_r;

    // MEM/WB register
    logic        mem_wb_reg_write_r;
    logic        mem_wb_mem_to_reg_r;
    logic [4:0]  mem_wb_write_reg_addr_r;
    logic [31:0] mem_wb_alu_result_r;
    logic [31:0] mem_wb_read_data_r;
    logic        mem_wb_misaligned_r;

    // Data memory (contents survive reset)
    logic [31:0] dmem_r [0:DMEM_WORDS-1];

    logic          advance_s;
    logic [AW-1:0] word_idx_s;
    logic          misaligned_s;
    logic          mem_we_s;
    logic [31:0]   write_back_s;

    // Decode the access in EX/MEM: word index, alignment and write enable
    always_comb begin
        advance_s    = reset & ~stall;
        word_idx_s   = ex_mem_alu_result_r[AW+1:2];
        misaligned_s = (ex_mem_alu_result_r[1:0] != 2'b00) &&
                       (ex_mem_mem_read_r || ex_mem_mem_write_r);
        mem_we_s     = advance_s & ex_mem_mem_write_r & ~misaligned_s;
    end

    // EX/MEM register: reset clears, stall holds, flush inserts a bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_mem_instr_r          <= 32'h0000_0000;
            ex_mem_alu_result_r     <= 32'h0000_0000;
            ex_mem_rt_data_r        <= 32'h0000_0000;
            ex_mem_mem_read_r       <= 1'b0;
            ex_mem_mem_write_r      <= 1'b0;
            ex_mem_mem_to_reg_r     <= 1'b0;
            ex_mem_reg_write_r      <= 1'b0;
            ex_mem_write_reg_addr_r <= 5'd0;
        end else if (!stall) begin
            if (flush) begin
                ex_mem_instr_r          <= 32'h0000_0000;
                ex_mem_alu_result_r     <= 32'h0000_0000;
                ex_mem_rt_data_r        <= 32'h0000_0000;
                ex_mem_mem_read_r       <= 1'b0;
                ex_mem_mem_write_r      <= 1'b0;
                ex_mem_mem_to_reg_r     <= 1'b0;
                ex_mem_reg_write_r      <= 1'b0;
                ex_mem_write_reg_addr_r <= 5'd0;
            end else begin
                ex_mem_instr_r          <= id_ex_instr;
                ex_mem_alu_result_r     <= alu_result;
                ex_mem_rt_data_r        <= alu_in2_out;
                ex_mem_mem_read_r       <= id_ex_mem_read;
                ex_mem_mem_write_r      <= id_ex_mem_write;
                ex_mem_mem_to_reg_r     <= id_ex_mem_to_reg;
                ex_mem_reg_write_r      <= id_ex_reg_write;
                ex_mem_write_reg_addr_r <= id_ex_write_reg_addr;
            end
        end
    end

    // Store port: aligned stores only, never on a reset or stalled edge
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            dmem_r[word_idx_s] <= ex_mem_rt_data_r;
        end
    end

    // MEM/WB register with synchronous memory read; a misaligned load's
    // register write is dropped here so the output stays registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_wb_reg_write_r      <= 1'b0;
            mem_wb_mem_to_reg_r     <= 1'b0;
            mem_wb_write_reg_addr_r <= 5'd0;
            mem_wb_alu_result_r     <= 32'h0000_0000;
            mem_wb_read_data_r      <= 32'h0000_0000;
            mem_wb_misaligned_r     <= 1'b0;
        end else if (!stall) begin
            mem_wb_reg_write_r      <= ex_mem_reg_write_r &
                                       ~(misaligned_s & ex_mem_mem_to_reg_r);
            mem_wb_mem_to_reg_r     <= ex_mem_mem_to_reg_r;
            mem_wb_write_reg_addr_r <= ex_mem_write_reg_addr_r;
            mem_wb_alu_result_r     <= ex_mem_alu_result_r;
            mem_wb_read_data_r      <= (ex_mem_mem_read_r && !misaligned_s) ?
                                       dmem_r[word_idx_s] : 32'h0000_0000;
            mem_wb_misaligned_r     <= misaligned_s;
        end
    end

    // Write-back select between loaded data and ALU result
    always_comb begin
        if (mem_wb_mem_to_reg_r) begin
            write_back_s = mem_wb_read_data_r;
        end else begin
            write_back_s = mem_wb_alu_result_r;
        end
    end

    assign ex_mem_instr             = ex_mem_instr_r;
    assign ex_mem_alu_result        = ex_mem_alu_result_r;
    assign ex_mem_reg_write         = ex_mem_reg_write_r;
    assign ex_mem_write_reg_addr    = ex_mem_write_reg_addr_r;
    assign ex_mem_mem_read          = ex_mem_mem_read_r;
    assign mem_wb_reg_write         = mem_wb_reg_write_r;
    assign mem_wb_write_reg_addr    = mem_wb_write_reg_addr_r;
    assign mem_wb_write_back_result = write_back_s;
    assign mem_wb_misaligned        = mem_wb_misaligned_r;

endmodule
